// File: rtl/call_register.sv
`timescale 1ns/1ps
// call_register
//   Turns raw detector / pushbutton inputs of a 12-channel intersection into
//   clean call requests for the light controller. Each input is synchronized
//   (2 flops) and then debounced. A channel's call is cleared while that
//   channel shows green/walk. Locking channels keep their call until they are
//   served. The block also tracks per-channel wait time, flags starvation,
//   and reports the oldest pending call.
//
// Ports
//   CLK          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-low reset
//   raw_det      in  12   unsynchronized inputs: [3:0] through W,E,N,S;
//                         [7:4] left-turn W,E,N,S; [11:8] pedestrian W,E,N,S
//   lights       in  24   channel i code at [2i+1:2i]; 2'b10 = green/walk.
//                         Assumed synchronous to CLK.
//   call         out 12   registered per-channel request
//   starve       out 12   registered: call pending >= MAX_WAIT cycles
//   oldest_idx   out  4   registered index of the pending call that has waited longest
//   oldest_valid out  1   registered: any call pending
module call_register #(
  parameter int unsigned DEB_CYCLES = 4,      // 1..15
  parameter int unsigned MAX_WAIT   = 200,    // 1..255
  parameter logic [11:0] LOCK_MASK  = 12'hF00
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [11:0] raw_det,
  input  logic [23:0] lights,
  output logic [11:0] call,
  output logic [11:0] starve,
  output logic [3:0]  oldest_idx,
  output logic        oldest_valid
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] WAIT_TH  = 8'(MAX_WAIT);

  logic [11:0]      r_s1;
  logic [11:0]      r_s2;
  logic [11:0]      r_deb;
  logic [11:0][3:0] r_deb_cnt;
  logic [11:0][7:0] r_wait;
  logic [11:0]      r_call;
  logic [11:0]      r_starve;
  logic [3:0]       r_oldest_idx;
  logic             r_oldest_valid;

  logic [11:0]      w_served;
  logic [11:0]      w_call_next;
  logic [11:0]      w_starve_next;
  logic [3:0]       w_best_idx;
  logic [7:0]       w_best_wait;
  logic             w_found;

  always_comb begin
    w_served      = '0;
    w_call_next   = '0;
    w_starve_next = '0;
    for (int i = 0; i < 12; i++) begin
      w_served[i] = (lights[2*i +: 2] == 2'b10);
      // Serving always wins over a new request on the same edge.
      if (w_served[i])
        w_call_next[i] = 1'b0;
      else if (LOCK_MASK[i])
        w_call_next[i] = r_call[i] | r_deb[i];
      else
        w_call_next[i] = r_deb[i];
      // Uses the next call value so starve drops on the same edge as call.
      w_starve_next[i] = (r_wait[i] >= WAIT_TH) & w_call_next[i];
    end
  end

  // Longest-waiting pending call; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_best_idx  = '0;
    w_best_wait = '0;
    w_found     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (r_call[i] && (!w_found || (r_wait[i] > w_best_wait))) begin
        w_found     = 1'b1;
        w_best_idx  = 4'(i);
        w_best_wait = r_wait[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_s1           <= '0;
      r_s2           <= '0;
      r_deb          <= '0;
      r_deb_cnt      <= '0;
      r_wait         <= '0;
      r_call         <= '0;
      r_starve       <= '0;
      r_oldest_idx   <= '0;
      r_oldest_valid <= 1'b0;
    end else begin
      r_s1 <= raw_det;
      r_s2 <= r_s1;
      for (int i = 0; i < 12; i++) begin
        // deb flips only after s2 disagrees for DEB_CYCLES consecutive edges.
        if (r_s2[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_deb[i]     <= ~r_deb[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
        // Wait counter saturates at 255.
        if (!r_call[i])
          r_wait[i] <= '0;
        else if (r_wait[i] != 8'hFF)
          r_wait[i] <= r_wait[i] + 8'd1;
      end
      r_call         <= w_call_next;
      r_starve       <= w_starve_next;
      r_oldest_idx   <= w_best_idx;
      r_oldest_valid <= w_found;
    end
  end

  assign call         = r_call;
  assign starve       = r_starve;
  assign oldest_idx   = r_oldest_idx;
  assign oldest_valid = r_oldest_valid;

endmodule
